// File: rtl/run_controller.sv
// run_controller: sequences one program run of a small core and arbitrates the
// single-port data RAM between the host and the core.
//
// Parameters:
//   MAX_CYCLES       RUN-cycle watchdog limit (1..65535)
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   host_go          level request to start a run
//   host_start_addr  program start address, captured on acceptance
//   host_mem_*       host data-memory access (req/we/addr/wdata), host_mem_gnt out
//   core_mem_*       decoder/register-file memory access (rd/wr/addr/wdata)
//   core_halt        decoder halt
//   ram_*            single-port RAM drive (readmem/writemem/addr/data)
//   core_start(_addr) fetch-unit start pulse and address
//   busy/done/timeout/cycle_count  run status
module run_controller #(
  parameter logic [15:0] MAX_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_go,
  input  logic [7:0]  host_start_addr,
  input  logic        host_mem_req,
  input  logic        host_mem_we,
  input  logic [7:0]  host_mem_addr,
  input  logic [7:0]  host_mem_wdata,
  output logic        host_mem_gnt,
  input  logic        core_mem_rd,
  input  logic        core_mem_wr,
  input  logic [7:0]  core_mem_addr,
  input  logic [7:0]  core_mem_wdata,
  input  logic        core_halt,
  output logic        ram_readmem,
  output logic        ram_writemem,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_data,
  output logic        core_start,
  output logic [7:0]  core_start_addr,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic        start_cnt_q, start_cnt_d;
  logic [7:0]  start_addr_q, start_addr_d;
  logic [15:0] count_q, count_d;
  logic        timeout_q, timeout_d;
  logic        accept;

  // A pending host access takes the RAM first; the run start waits for it.
  assign accept = host_go & ~host_mem_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      start_cnt_q  <= 1'b0;
      start_addr_q <= 8'h00;
      count_q      <= 16'h0000;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_cnt_q  <= start_cnt_d;
      start_addr_q <= start_addr_d;
      count_q      <= count_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    start_cnt_d  = start_cnt_q;
    start_addr_d = start_addr_q;
    count_d      = count_q;
    timeout_d    = timeout_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d      = StStart;
          start_cnt_d  = 1'b0;
          start_addr_d = host_start_addr;
          count_d      = 16'h0000;
          timeout_d    = 1'b0;
        end
      end
      StStart: begin
        // core_start is held for two cycles; halt is not looked at here.
        if (start_cnt_q) begin
          state_d = StRun;
        end else begin
          start_cnt_d = 1'b1;
        end
      end
      StRun: begin
        // The final RUN cycle (halt or watchdog) is counted too.
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
        if (core_halt) begin
          state_d   = StDone;
          timeout_d = 1'b0;
        end else if (count_q == MAX_CYCLES - 16'd1) begin
          state_d   = StDone;
          timeout_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy            = (state_q == StStart) || (state_q == StRun);
  assign done            = (state_q == StDone);
  assign core_start      = (state_q == StStart);
  assign core_start_addr = start_addr_q;
  assign cycle_count     = count_q;
  assign timeout         = timeout_q;

  // RAM arbitration: the core owns the port while busy, the host otherwise.
  always_comb begin
    ram_readmem  = 1'b0;
    ram_writemem = 1'b0;
    ram_addr     = 8'h00;
    ram_data     = 8'h00;
    host_mem_gnt = 1'b0;
    if (busy) begin
      ram_writemem = core_mem_wr;
      ram_readmem  = core_mem_rd & ~core_mem_wr;  // write wins
      if (core_mem_rd || core_mem_wr) begin
        ram_addr = core_mem_addr;
        ram_data = core_mem_wdata;
      end
    end else if (host_mem_req) begin
      host_mem_gnt = 1'b1;
      ram_writemem = host_mem_we;
      ram_readmem  = ~host_mem_we;
      ram_addr     = host_mem_addr;
      ram_data     = host_mem_wdata;
    end
    // Reset kills any RAM strobe immediately, whatever is requested.
    if (!rst_n) begin
      ram_readmem  = 1'b0;
      ram_writemem = 1'b0;
      ram_addr     = 8'h00;
      ram_data     = 8'h00;
      host_mem_gnt = 1'b0;
    end
  end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 16'd1000, the RUN-cycle watchdog limit; legal range 1..65535.
REQ-002 SHALL have port clk  in  1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-004 SHALL have port host_go  in  1: level-sensitive request to start a program run.
REQ-005 SHALL have port host_start_addr  in  8: program start address, captured when a run is accepted.
REQ-006 SHALL have ports host_mem_req  in  1, host_mem_we  in  1, host_mem_addr  in  8, host_mem_wdata  in  8: host data-memory access.
REQ-007 SHALL have port host_mem_gnt  out  1: host access is performed this cycle.
REQ-008 SHALL have ports core_mem_rd  in  1, core_mem_wr  in  1, core_mem_addr  in  8, core_mem_wdata  in  8: decoder/register-file memory access.
REQ-009 SHALL have port core_halt  in  1: decoder halt.
REQ-010 SHALL have ports ram_readmem  out  1, ram_writemem  out  1, ram_addr  out  8, ram_data  out  8: single-port data RAM drive.
REQ-011 SHALL have ports core_start  out  1 and core_start_addr  out  8: drive the fetch unit start and start_addr inputs.
REQ-012 SHALL have ports busy  out  1, done  out  1, timeout  out  1 and cycle_count  out  16: run status.

Function
REQ-013 SHALL implement states IDLE, START, RUN and DONE, encoded in one registered state variable.
REQ-014 SHALL leave IDLE or DONE for START on a cycle where host_go=1 and host_mem_req=0; a pending host access defers acceptance.
REQ-015 SHALL, on acceptance, capture host_start_addr into core_start_addr, clear cycle_count, and clear done and timeout.
REQ-016 SHALL hold core_start=1 for exactly 2 cycles (START counter 0,1), then enter RUN; core_halt is ignored in START.
REQ-017 SHALL increment cycle_count by 1 on every RUN cycle, saturating at 16'hFFFF.
REQ-018 SHALL move RUN->DONE with timeout=0 on the edge where core_halt=1; cycle_count then includes that halt cycle.
REQ-019 SHALL move RUN->DONE with timeout=1 when cycle_count==MAX_CYCLES-1 and core_halt=0.
REQ-020 SHALL give halt priority when halt and the watchdog limit coincide: timeout=0.
REQ-021 SHALL hold done=1 in DONE until the next accepted run; cycle_count and timeout hold their final values.
REQ-022 SHALL set busy=1 exactly in START and RUN.
REQ-023 SHALL compute RAM arbitration combinationally from the state.
REQ-024 SHALL, in START or RUN: ram_readmem=core_mem_rd, ram_writemem=core_mem_wr, ram_addr=core_mem_addr, ram_data=core_mem_wdata, host_mem_gnt=0.
REQ-025 SHALL, in IDLE or DONE: host_mem_gnt=host_mem_req, ram_writemem=host_mem_req&host_mem_we, ram_readmem=host_mem_req&~host_mem_we, ram_addr=host_mem_addr, ram_data=host_mem_wdata; core requests are ignored.
REQ-026 SHALL drive ram_readmem=0, ram_writemem=0 and ram_addr/ram_data=0 when neither side requests.
REQ-027 SHALL never assert ram_readmem and ram_writemem in the same cycle; if the core asserts both, write wins and read is forced to 0.
REQ-028 SHALL not queue host requests made during START or RUN; the host holds host_mem_req until host_mem_gnt=1.

Reset
REQ-029 SHALL, while rst_n=0, force immediately (asynchronously): state=IDLE, core_start=0, core_start_addr=0, cycle_count=0, busy=0, done=0, timeout=0.
REQ-030 SHALL, while rst_n=0, force ram_readmem=0, ram_writemem=0 and host_mem_gnt=0 regardless of requests.
REQ-031 SHALL, on reset assertion mid-RUN, abort the run with no DONE state and no done pulse; the first edge after release is in IDLE.

Verification
REQ-032 Bench SHALL cover: rst_n release, host writes 8'h55 to addr 8'h10 in IDLE -> host_mem_gnt=1, ram_writemem=1, ram_addr=8'h10 that cycle.
REQ-033 Bench SHALL cover: host_go with start_addr 8'h20 -> core_start=1 for 2 cycles, core_start_addr=8'h20; core_halt 5 RUN cycles later -> done=1, cycle_count=6, timeout=0.
REQ-034 Bench SHALL cover: MAX_CYCLES=8, no halt -> DONE after 8 RUN cycles, timeout=1, cycle_count=8; halt on 8th cycle -> timeout=0.
REQ-035 Bench SHALL cover: host_mem_req held during RUN -> gnt=0, RAM follows core; grant in first DONE cycle.
REQ-036 Bench SHALL cover: host_go and host_mem_req both high in IDLE -> access granted, go deferred one cycle.
REQ-037 Bench SHALL cover: rst_n=0 mid-RUN with core_mem_wr=1 -> ram_writemem=0 immediately, busy=0, state IDLE after release.
